// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, flag bundle and reserved-op decode
// used by the ALU result stage.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } alu_flags_t;

    localparam alu_op_t ALU_PASS_B = 3'b000;
    localparam alu_op_t ALU_RSVD1  = 3'b001;
    localparam alu_op_t ALU_ADD    = 3'b010;
    localparam alu_op_t ALU_SUB    = 3'b011;
    localparam alu_op_t ALU_AND    = 3'b100;
    localparam alu_op_t ALU_OR     = 3'b101;
    localparam alu_op_t ALU_XOR    = 3'b110;
    localparam alu_op_t ALU_RSVD7  = 3'b111;

    function automatic logic is_reserved_op(input alu_op_t op);
        return (op == ALU_RSVD1) || (op == ALU_RSVD7);
    endfunction

endpackage

// File: rtl/alu_result_stage_zero_detect64.sv
// zero_detect64: balanced OR-reduction tree over the result word, inverted
// at the root to give the Z flag.
module zero_detect64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] word,
    output logic             zero
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int PADDED = 1 << LEVELS;

    logic [PADDED-1:0] tree;

    // Each level folds adjacent pairs in place; the low slots always hold
    // the most recent level, so tree[0] ends up as the OR of every bit.
    always_comb begin
        tree = '0;
        tree[WIDTH-1:0] = word;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int i = 0; i < (PADDED >> (lvl + 1)); i++) begin
                tree[i] = tree[2*i] | tree[2*i+1];
            end
        end
        zero = ~tree[0];
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage after the ALU result-select muxes, with N/Z/V/C
// flag register. Define ALU_RESULT_SKID_EN for a 2-entry skid buffer.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_op,
    input  logic             in_set_flags,
    input  logic             in_carry_out,
    input  logic             in_carry_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c,
    output logic             err_reserved
);

    logic             accept;
    logic             deliver;
    logic             op_reserved;
    logic             in_zero;
    logic [WIDTH-1:0] load_result;
    alu_flags_t       flags;
    alu_flags_t       new_flags;

    assign accept      = in_valid & in_ready;
    assign deliver     = out_valid & out_ready;
    assign op_reserved = is_reserved_op(in_op);
    assign load_result = op_reserved ? '0 : in_result;

    zero_detect64 #(.WIDTH(WIDTH)) u_zero_detect (
        .word (in_result),
        .zero (in_zero)
    );

    always_comb begin
        new_flags   = '0;
        new_flags.n = in_result[WIDTH-1];
        new_flags.z = in_zero;
        if (in_op == ALU_ADD || in_op == ALU_SUB) begin
            new_flags.c = in_carry_out;
            new_flags.v = in_carry_msb ^ in_carry_out;
        end
    end

    // Flags follow acceptance order, so they update here rather than on delivery.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags        <= '0;
            err_reserved <= 1'b0;
        end else if (accept) begin
            if (op_reserved) begin
                err_reserved <= 1'b1;
            end else if (in_set_flags) begin
                flags <= new_flags;
            end
        end
    end

    assign flag_n = flags.n;
    assign flag_z = flags.z;
    assign flag_v = flags.v;
    assign flag_c = flags.c;

`ifdef ALU_RESULT_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_result;
    logic [2:0]       skid_op;
    logic             main_load_in;
    logic             main_load_skid;
    logic             main_clear;
    logic             skid_load;
    logic             skid_clear;

    // skid_valid is a flop, so in_ready carries no combinational path from out_ready.
    assign in_ready = ~skid_valid;

    always_comb begin
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (skid_valid) begin
            if (deliver) begin
                main_load_skid = 1'b1;
                skid_clear     = 1'b1;
            end
        end else if (!out_valid || deliver) begin
            if (accept) begin
                main_load_in = 1'b1;
            end else if (deliver) begin
                main_clear = 1'b1;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_op      <= '0;
            skid_valid  <= 1'b0;
            skid_result <= '0;
            skid_op     <= '0;
        end else begin
            if (main_load_in) begin
                out_valid  <= 1'b1;
                out_result <= load_result;
                out_op     <= in_op;
            end else if (main_load_skid) begin
                out_valid  <= 1'b1;
                out_result <= skid_result;
                out_op     <= skid_op;
            end else if (main_clear) begin
                out_valid <= 1'b0;
            end
            if (skid_load) begin
                skid_valid  <= 1'b1;
                skid_result <= load_result;
                skid_op     <= in_op;
            end else if (skid_clear) begin
                skid_valid <= 1'b0;
            end
        end
    end
`else
    assign in_ready = out_ready | ~out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= load_result;
            out_op     <= in_op;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: scoreboard of accepted entries
// plus directed flag, reserved-op, backpressure, streaming and reset checks.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int WIDTH = 64;
`ifdef ALU_RESULT_SKID_EN
    localparam int STALL_ACCEPTS = 1;
`else
    localparam int STALL_ACCEPTS = 0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [2:0]       op;
    } entry_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [2:0]       in_op;
    logic             in_set_flags;
    logic             in_carry_out;
    logic             in_carry_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_op;
    logic             flag_n;
    logic             flag_z;
    logic             flag_v;
    logic             flag_c;
    logic             err_reserved;

    entry_t sb[$];
    entry_t got;
    entry_t exp_e;
    logic   acc;
    logic   dlv;
    int     checks = 0;
    int     fails  = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_op        (in_op),
        .in_set_flags (in_set_flags),
        .in_carry_out (in_carry_out),
        .in_carry_msb (in_carry_msb),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_op       (out_op),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .flag_v       (flag_v),
        .flag_c       (flag_c),
        .err_reserved (err_reserved)
    );

    task automatic set_in(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] res,
                          input logic sf, input logic co, input logic cm);
        in_valid     = v;
        in_op        = op;
        in_result    = res;
        in_set_flags = sf;
        in_carry_out = co;
        in_carry_msb = cm;
    endtask

    // Samples handshakes before the edge, queues the expected entry on accept,
    // then returns 1 time unit after the edge.
    task automatic tick(output logic a, output logic d, output entry_t g);
        entry_t e;
        #1;
        a = in_valid && in_ready && !reset;
        d = out_valid && out_ready && !reset;
        g.result = out_result;
        g.op     = out_op;
        if (a) begin
            e.op     = in_op;
            e.result = (in_op == 3'b001 || in_op == 3'b111) ? '0 : in_result;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        set_in(1'b1, ALU_ADD, '1, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0 || out_op !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got valid=%0b result=%h op=%0d, expected 0/0/0", out_valid, out_result, out_op);
        end
        checks++;
        if ({flag_n, flag_z, flag_v, flag_c, err_reserved} !== 5'b00000) begin
            fails++;
            $display("[TB] FAIL reset_flags: got nzvc=%b err=%b, expected 0000/0", {flag_n, flag_z, flag_v, flag_c}, err_reserved);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b expected 1", in_ready);
        end
        reset = 1'b0;
        set_in(1'b0, ALU_PASS_B, '0, 1'b0, 1'b0, 1'b0);
        sb.delete();
    endtask

    task automatic test_add_single();
        out_ready = 1'b1;
        set_in(1'b1, ALU_ADD, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        tick(acc, dlv, got);
        set_in(1'b0, ALU_PASS_B, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 64'h8000_0000_0000_0000) begin
            fails++;
            $display("[TB] FAIL add_latency: got valid=%b result=%h, expected 1/8000000000000000", out_valid, out_result);
        end
        checks++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b1010) begin
            fails++;
            $display("[TB] FAIL add_flags: got nzvc=%b expected 1010", {flag_n, flag_z, flag_v, flag_c});
        end
        tick(acc, dlv, got);
        checks++;
        if (!dlv || sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL add_deliver: got delivered=%b queued=%0d, expected a delivery", dlv, sb.size());
        end else begin
            exp_e = sb.pop_front();
            if (got !== exp_e) begin
                fails++;
                $display("[TB] FAIL add_entry: got %h/%0d expected %h/%0d", got.result, got.op, exp_e.result, exp_e.op);
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL add_valid_drop: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_sub_and();
        sb.delete();
        out_ready = 1'b1;
        set_in(1'b1, ALU_SUB, '0, 1'b1, 1'b1, 1'b1);
        tick(acc, dlv, got);
        set_in(1'b0, ALU_PASS_B, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101) begin
            fails++;
            $display("[TB] FAIL sub_flags: got nzvc=%b expected 0101", {flag_n, flag_z, flag_v, flag_c});
        end
        tick(acc, dlv, got);
        checks++;
        if (!dlv || sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL sub_deliver: got delivered=%b queued=%0d, expected a delivery", dlv, sb.size());
        end else begin
            exp_e = sb.pop_front();
            if (got !== exp_e) begin
                fails++;
                $display("[TB] FAIL sub_entry: got %h/%0d expected %h/%0d", got.result, got.op, exp_e.result, exp_e.op);
            end
        end
        set_in(1'b1, ALU_AND, 64'hFF, 1'b0, 1'b1, 1'b0);
        tick(acc, dlv, got);
        set_in(1'b0, ALU_PASS_B, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101 || out_result !== 64'hFF) begin
            fails++;
            $display("[TB] FAIL and_noflags: got nzvc=%b result=%h expected 0101/ff", {flag_n, flag_z, flag_v, flag_c}, out_result);
        end
        tick(acc, dlv, got);
        checks++;
        if (!dlv || sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL and_deliver: got delivered=%b queued=%0d, expected a delivery", dlv, sb.size());
        end else begin
            exp_e = sb.pop_front();
            if (got !== exp_e) begin
                fails++;
                $display("[TB] FAIL and_entry: got %h/%0d expected %h/%0d", got.result, got.op, exp_e.result, exp_e.op);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_acc;
        int n_dlv;
        sb.delete();
        out_ready = 1'b0;
        set_in(1'b1, ALU_XOR, 64'h1234, 1'b0, 1'b0, 1'b0);
        tick(acc, dlv, got);
        checks++;
        if (acc !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bp_first_accept: got %b expected 1", acc);
        end
        set_in(1'b1, ALU_OR, 64'h5678, 1'b0, 1'b0, 1'b0);
        n_acc = 0;
        for (int c = 0; c < 3; c++) begin
            tick(acc, dlv, got);
            if (acc) begin
                n_acc++;
                in_valid = 1'b0;
            end
            checks++;
            if (out_valid !== 1'b1 || out_result !== 64'h1234 || out_op !== ALU_XOR) begin
                fails++;
                $display("[TB] FAIL bp_hold cycle %0d: got valid=%b result=%h op=%0d expected 1/1234/6", c, out_valid, out_result, out_op);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL bp_ready cycle %0d: got %b expected 0", c, in_ready);
            end
        end
        checks++;
        if (n_acc != STALL_ACCEPTS) begin
            fails++;
            $display("[TB] FAIL bp_stall_accepts: got %0d expected %0d", n_acc, STALL_ACCEPTS);
        end
        out_ready = 1'b1;
        n_dlv = 0;
        for (int c = 0; c < 4 && n_dlv < 2; c++) begin
            tick(acc, dlv, got);
            if (acc) in_valid = 1'b0;
            if (dlv) begin
                n_dlv++;
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL bp_extra: got %h with empty scoreboard", got.result);
                end else begin
                    exp_e = sb.pop_front();
                    if (got !== exp_e) begin
                        fails++;
                        $display("[TB] FAIL bp_order: got %h/%0d expected %h/%0d", got.result, got.op, exp_e.result, exp_e.op);
                    end
                end
            end else begin
                checks++;
                fails++;
                $display("[TB] FAIL bp_bubble cycle %0d: got no delivery, expected one per cycle", c);
            end
        end
        checks++;
        if (n_dlv != 2 || sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL bp_drain: got %0d deliveries, %0d left, expected 2/0", n_dlv, sb.size());
        end
    endtask

    task automatic test_reserved();
        sb.delete();
        out_ready = 1'b1;
        set_in(1'b1, ALU_RSVD7, 64'hDEAD, 1'b1, 1'b1, 1'b0);
        tick(acc, dlv, got);
        set_in(1'b1, ALU_RSVD1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_result !== '0 || out_op !== 3'b111 || err_reserved !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rsvd7_out: got result=%h op=%0d err=%b expected 0/7/1", out_result, out_op, err_reserved);
        end
        checks++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101) begin
            fails++;
            $display("[TB] FAIL rsvd7_flags: got nzvc=%b expected 0101", {flag_n, flag_z, flag_v, flag_c});
        end
        tick(acc, dlv, got);
        set_in(1'b1, ALU_ADD, 64'h1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!dlv || sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL rsvd_deliver: got delivered=%b queued=%0d, expected a delivery", dlv, sb.size());
        end else begin
            exp_e = sb.pop_front();
            if (got !== exp_e) begin
                fails++;
                $display("[TB] FAIL rsvd_entry: got %h/%0d expected %h/%0d", got.result, got.op, exp_e.result, exp_e.op);
            end
        end
        checks++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101 || out_result !== '0) begin
            fails++;
            $display("[TB] FAIL rsvd1_out: got nzvc=%b result=%h expected 0101/0", {flag_n, flag_z, flag_v, flag_c}, out_result);
        end
        tick(acc, dlv, got);
        set_in(1'b0, ALU_PASS_B, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0000 || err_reserved !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rsvd_sticky: got nzvc=%b err=%b expected 0000/1", {flag_n, flag_z, flag_v, flag_c}, err_reserved);
        end
        tick(acc, dlv, got);
        checks++;
        if (err_reserved !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rsvd_sticky_idle: got err=%b valid=%b expected 1/0", err_reserved, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int          first;
        int          last;
        int          n_dlv;
        logic [63:0] val;
        sb.delete();
        out_ready = 1'b1;
        first = -1;
        last  = -1;
        n_dlv = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                val = {32'hA5A5_0000 + 32'(c), 32'(c * 7 + 1)};
                set_in(1'b1, (c % 2 == 1) ? ALU_OR : ALU_ADD, val, 1'b0, 1'b0, 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            tick(acc, dlv, got);
            if (c < 8) begin
                checks++;
                if (acc !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL b2b_accept %0d: got %b expected 1", c, acc);
                end
            end
            if (dlv) begin
                if (first < 0) first = c;
                last = c;
                n_dlv++;
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL b2b_extra: got %h with empty scoreboard", got.result);
                end else begin
                    exp_e = sb.pop_front();
                    if (got !== exp_e) begin
                        fails++;
                        $display("[TB] FAIL b2b_order: got %h/%0d expected %h/%0d", got.result, got.op, exp_e.result, exp_e.op);
                    end
                end
            end
        end
        checks++;
        if (n_dlv != 8 || last - first != 7) begin
            fails++;
            $display("[TB] FAIL b2b_stream: got %0d deliveries over span %0d, expected 8 over 7", n_dlv, last - first);
        end
    endtask

    task automatic test_reset_midflight();
        int n_dlv;
        sb.delete();
        out_ready = 1'b0;
        set_in(1'b1, ALU_ADD, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b1);
        tick(acc, dlv, got);
        set_in(1'b0, ALU_PASS_B, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || {flag_n, flag_z, flag_v, flag_c} !== 4'b1001) begin
            fails++;
            $display("[TB] FAIL rst_setup: got valid=%b nzvc=%b expected 1/1001", out_valid, {flag_n, flag_z, flag_v, flag_c});
        end
        reset = 1'b1;
        set_in(1'b1, ALU_SUB, 64'h77, 1'b1, 1'b1, 1'b0);
        tick(acc, dlv, got);
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0 || err_reserved !== 1'b0 ||
            {flag_n, flag_z, flag_v, flag_c} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL rst_clear: got valid=%b result=%h err=%b nzvc=%b expected 0/0/0/0000",
                     out_valid, out_result, err_reserved, {flag_n, flag_z, flag_v, flag_c});
        end
        reset = 1'b0;
        sb.delete();
        set_in(1'b0, ALU_PASS_B, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        n_dlv = 0;
        for (int c = 0; c < 4; c++) begin
            tick(acc, dlv, got);
            if (dlv) n_dlv++;
        end
        checks++;
        if (n_dlv != 0 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rst_ghost: got %0d deliveries ready=%b expected 0/1", n_dlv, in_ready);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add_single();
        test_sub_and();
        test_backpressure();
        test_reserved();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the per-bit 8:1 result-select muxes in the 64-bit ALU.
- Captures the selected result word, the 3-bit ALU control and adder carry information, and forwards the result over a valid/ready handshake.
- Maintains the architectural N/Z/V/C flag register for flag-setting ops (ADDS/SUBS/ANDS).

Parameters:
- WIDTH, 64, data width; sign bit is WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept this cycle
- in_result  input  WIDTH  word from result-select muxes
- in_op  input  3  ALU control that produced in_result
- in_set_flags  input  1  update flags on acceptance
- in_carry_out  input  1  adder carry out of bit WIDTH-1
- in_carry_msb  input  1  adder carry into bit WIDTH-1
- out_valid  output  1  result available downstream
- out_ready  input  1  downstream accepts
- out_result  output  WIDTH  registered result
- out_op  output  3  registered ALU control
- flag_n, flag_z, flag_v, flag_c  output  1 each  architectural flags
- err_reserved  output  1  sticky: reserved op accepted

Behaviour:
- Accept = in_valid & in_ready; deliver = out_valid & out_ready.
- Reset (synchronous, sampled at clk edge) clears out_valid, out_result, out_op, all flags and err_reserved to 0. Any in-flight entry is dropped. Inputs are ignored in the reset cycle.
- Op encoding:
  - 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR.
  - 001 and 111 are reserved.
- Base mode is a single register:
  - in_ready = out_ready | ~out_valid (combinational).
  - On accept, the entry loads and out_valid = 1 on the next cycle, so latency is 1 cycle.
  - On deliver without accept, out_valid goes to 0.
  - Simultaneous deliver and accept: the new entry replaces the old one with no bubble.
  - While out_valid & ~out_ready, out_result and out_op hold stable.
- Reserved op accepted:
  - out_result is forced to 0 regardless of in_result.
  - err_reserved is set to 1 and stays set until reset.
  - Flags are unchanged even if in_set_flags = 1.
- Flag update occurs on accept with in_set_flags = 1 and a non-reserved op, and is visible the next cycle:
  - N = in_result[WIDTH-1].
  - Z = (in_result == 0).
  - ADD/SUB: C = in_carry_out, V = in_carry_msb ^ in_carry_out.
  - PASS_B/AND/OR/XOR: C = 0, V = 0.
- in_set_flags = 0: flags are held.
- Flags are ordered by acceptance, not delivery.

Optional Feature:
- Macro: ALU_RESULT_SKID_EN.
- Defined:
  - Adds a 2-entry skid buffer (main + skid).
  - in_ready is registered, equal to ~skid_full.
  - When the main entry is stalled and an entry is accepted, that entry goes to skid.
  - On the next deliver, skid moves to main.
  - Order is preserved and full throughput is sustained under a stalled out_ready.
  - in_ready is 1 after reset.
  - Flag and error rules are unchanged, still applied at accept.
- Undefined: base single-register mode as above.

Decomposition:
- Package alu_pkg holds:
  - localparams ALU_PASS_B, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_RSVD1, ALU_RSVD7;
  - typedef alu_op_t (logic [2:0]);
  - typedef alu_flags_t (packed struct n, z, v, c).
- One sub-module: zero_detect64, a tree-reduced NOR producing Z for the WIDTH-bit word.

Test Plan:
- Reset then single accept of ADD, result 0x8000_0000_0000_0000, carry_msb = 1, carry_out = 0, set_flags = 1, out_ready = 1 -> next cycle out_valid = 1 and out_result equals that word; flags N=1 Z=0 V=1 C=0; out_valid = 0 one cycle later.
- SUB, result 0, carry_out = 1, carry_msb = 1, set_flags = 1 -> N=0 Z=1 V=0 C=1. Then AND, result 0xFF, set_flags = 0 -> flags unchanged.
- Backpressure: accept XOR 0x1234 with out_ready = 0 for 3 cycles -> out_result holds 0x1234 and out_valid stays 1. In base mode in_ready = 0 during the stall; with the skid enabled, one extra entry is accepted and then in_ready = 0. Raise out_ready -> both entries delivered in order, one per cycle.
- Reserved op 111 with in_result 0xDEAD and set_flags = 1 -> out_result = 0, err_reserved = 1 sticky, flags unchanged. Next legal ops do not clear err_reserved.
- Streaming 8 back-to-back ADD/OR entries with out_ready = 1 -> 8 consecutive out_valid cycles with no bubble, all in order.
- Reset asserted while out_valid = 1 and stalled -> next cycle out_valid = 0, flags = 0, err_reserved = 0, and the dropped entry is never delivered.
